rom_loader: RTL and testbench

//  Streams a Chip-8 program image from a byte source (UART/SPI front end) into the CPU's dual-port memory via port A.

---
 rtl/chip8_pkg.sv | 23 ++
 rtl/loader_timeout.sv | 34 +++
 rtl/rom_loader.sv | 167 ++++++++++++++++
 tb/tb_rom_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared Chip-8 memory map constants and the rom_loader state encoding.
// Ports: none (package). Imported by rom_loader and loader_timeout.
// States are plain localparam vectors so older tools and hand-written decoders can share them.
package chip8_pkg;

  localparam int          MEM_ADDR_W   = 12;
  localparam logic [11:0] PROGRAM_BASE = 12'h200;
  localparam int          MEM_SIZE     = 4096;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // States in which a load is in flight and source bytes are accepted.
  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_LEN_HI) || (st == ST_LEN_LO) || (st == ST_DATA) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle down-counter; load restarts the window, run counts idle cycles.
// Ports: clk, reset (async active-high), load, run in; expired out (combinational).
// expired is high in the run cycle whose edge completes TIMEOUT idle cycles since the last load.
module loader_timeout
  import chip8_pkg::*;
#(
  parameter int          W       = 24,
  parameter logic [W-1:0] TIMEOUT = 24'd5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt;

  // Loading TIMEOUT-1 makes the TIMEOUT-th idle edge the one that sees cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TIMEOUT - ONE;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/rom_loader.sv
// rom_loader: streams a length-framed Chip-8 image from a byte source into memory port A,
//   holding the CPU in reset until the whole image has been written.
// Ports: clk, reset, start, in_valid/in_data/in_ready (byte source), mem_en/mem_write/mem_addr/
//   mem_data (memory port A), cpu_hold, busy, done, error, byte_count.
// Optional macro ROM_LOADER_CHECKSUM_EN adds a trailing 8-bit modulo-sum byte checked in CHECK.
module rom_loader
  import chip8_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] LOAD_BASE = PROGRAM_BASE,
  parameter logic [MEM_ADDR_W-1:0] MAX_LEN   = 12'hE00,
  parameter logic [23:0]           TIMEOUT   = 24'd5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_en,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [MEM_ADDR_W-1:0] byte_count
);

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CHECK;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  logic [2:0]  state;
  logic [15:0] len;
  logic        active;
  logic        xfer;
  logic        start_ok;
  logic        last_byte;
  logic        tmo_expired;

  assign active    = is_active(state);
  assign in_ready  = active;
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign last_byte = ({4'd0, byte_count} + 16'd1) == len;

  loader_timeout #(
    .W       (24),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok || xfer),
    .run     (active && !xfer),
    .expired (tmo_expired)
  );

`ifdef ROM_LOADER_CHECKSUM_EN
  // Running modulo-256 sum of both length bytes and every payload byte.
  logic [7:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= 8'd0;
    end else if (start_ok) begin
      sum <= 8'd0;
    end else if (xfer && (state != ST_CHECK)) begin
      sum <= sum + in_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      len        <= 16'd0;
      mem_en     <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= 8'd0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data simply hold.
      mem_en    <= 1'b0;
      mem_write <= 1'b0;
      if (start_ok) begin
        state      <= ST_LEN_HI;
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        cpu_hold   <= 1'b1;
        byte_count <= '0;
      end else if (tmo_expired) begin
        state <= ST_ERROR;
        busy  <= 1'b0;
        error <= 1'b1;
      end else begin
        case (state)
          ST_LEN_HI: begin
            if (xfer) begin
              len[15:8] <= in_data;
              state     <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (xfer) begin
              len[7:0] <= in_data;
              if ({len[15:8], in_data} > {4'd0, MAX_LEN}) begin
                state <= ST_ERROR;
                busy  <= 1'b0;
                error <= 1'b1;
              end else if ({len[15:8], in_data} == 16'd0) begin
                state <= ST_AFTER_DATA;
              end else begin
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (xfer) begin
              mem_en     <= 1'b1;
              mem_write  <= 1'b1;
              mem_addr   <= LOAD_BASE + byte_count;
              mem_data   <= in_data;
              byte_count <= byte_count + 12'd1;
              if (last_byte) begin
                state <= ST_AFTER_DATA;
              end
            end
          end
`ifdef ROM_LOADER_CHECKSUM_EN
          ST_CHECK: begin
            if (xfer) begin
              if (in_data == sum) begin
                state <= ST_DONE;
              end else begin
                state <= ST_ERROR;
                busy  <= 1'b0;
                error <= 1'b1;
              end
            end
          end
`endif
          ST_DONE: begin
            // Status lags entry by one cycle so the final write pulse lands
            // before the CPU is released.
            if (busy) begin
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader (TIMEOUT overridden to 100 cycles).
// Ports: none. Expected memory writes are queued as bytes are driven and popped by a write monitor.
// Build with ROM_LOADER_CHECKSUM_EN to exercise the trailer-byte path.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_en;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] byte_count;

  always #5 clk = ~clk;

  rom_loader #(
    .TIMEOUT (24'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_en     (mem_en),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          extra_wr = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  pay[$];
  logic [19:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write monitor: every mem_en pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        extra_wr++;
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_write", {mem_write, mem_addr, mem_data}, {1'b1, mon_e});
      end
    end
  end

  task automatic check_reset(input string tag);
    check(tag, {in_ready, mem_en, mem_write, cpu_hold, busy, done, error}, 7'b0001000);
    check({tag, "_regs"}, {mem_addr, mem_data, byte_count}, 32'd0);
  endtask

  // Caller is at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends header, the first npay entries of pay[], and (checksum build) a trailer
  // when the payload is complete; cs_delta corrupts the trailer.
  task automatic send_image(input logic [15:0] len, input int npay, input logic [7:0] cs_delta);
    logic [7:0] s;
    s = len[15:8] + len[7:0];
    send(len[15:8]);
    send(len[7:0]);
    for (int i = 0; i < npay; i++) begin
      exp_q.push_back({12'h200 + i[11:0], pay[i]});
      s = s + pay[i];
      send(pay[i]);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    if (npay == int'(len)) send(s + cs_delta);
`else
    if (cs_delta != 8'd0) s = s + cs_delta;
`endif
  endtask

  task automatic wait_end(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    while (!(done || error) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {done, error}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset_vals");
    reset = 1'b0;
    @(negedge clk);
    check_reset("idle_vals");

    // Basic 3-byte load, with a start pulse during the load that must be ignored.
    pulse_start();
    check("start_flags", {busy, cpu_hold, done, error, in_ready}, 5'b11001);
    pulse_start();
    check("start_while_busy", {busy, in_ready, byte_count}, {2'b11, 12'd0});
    pay = '{8'hA1, 8'hB2, 8'hC3};
    send_image(16'd3, 3, 8'd0);
    check("hold_until_after_write", {done, cpu_hold}, 2'b01);
    @(negedge clk);
    check("basic_done", {done, cpu_hold, busy, error}, 4'b1000);
    check("basic_count", byte_count, 3);
    check("basic_all_written", exp_q.size(), 0);

    // Oversize header: error after LEN_LO, no writes, source stalled.
    pulse_start();
    check("restart_from_done", {busy, done, cpu_hold}, 3'b101);
    send_image(16'h0E01, 0, 8'd0);
    check("oversize_err", {error, busy, cpu_hold, in_ready, done}, 5'b10100);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("err_no_consume", {error, in_ready, byte_count}, {2'b10, 12'd0});
    check("oversize_no_write", extra_wr, 0);

    // Zero-length image.
    pulse_start();
    send_image(16'd0, 0, 8'd0);
    wait_end("zero_len", 2'b10);
    check("zero_len_count", {byte_count, cpu_hold}, {12'd0, 1'b0});

    // Timeout: stall after 2 of 5 payload bytes.
    pulse_start();
    pay = '{8'h11, 8'h22};
    send_image(16'd5, 2, 8'd0);
    repeat (99) @(negedge clk);
    check("tmo_not_early", error, 0);
    @(negedge clk);
    check("tmo_exact", {error, busy, cpu_hold}, 3'b101);
    check("tmo_count", byte_count, 2);

    // Two-byte image; checksum build also checks a good and a bad trailer.
    pulse_start();
    pay = '{8'h10, 8'h20};
    send_image(16'd2, 2, 8'd0);
    wait_end("cs_good", 2'b10);
    check("cs_good_count", byte_count, 2);
`ifdef ROM_LOADER_CHECKSUM_EN
    pulse_start();
    send_image(16'd2, 2, 8'd1);
    wait_end("cs_bad", 2'b01);
    check("cs_bad_hold", {byte_count, cpu_hold}, {12'd2, 1'b1});
`else
    in_valid = 1'b1; in_data = 8'h33;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done_no_consume", {done, byte_count}, {1'b1, 12'd2});
`endif

    // Reset after 5 of 10 payload bytes, then a clean 1-byte load.
    pulse_start();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_image(16'd10, 5, 8'd0);
    reset = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    pay = '{8'h5A};
    send_image(16'd1, 1, 8'd0);
    wait_end("restart_done", 2'b10);
    check("restart_count", {byte_count, cpu_hold}, {12'd1, 1'b0});

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("no_extra_writes", extra_wr, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
